// File: rtl/ssp_frame_ctrl.sv
// ----------------------------------------------------------------------------
// ssp_frame_ctrl
//
// Frame sequencer for a simple synchronous serial port. It pops one word from
// the transmit FIFO and sends a frame-sync pulse, then shifts DW bits out MSB
// first while it samples DW bits in. It then pushes the received word into the
// receive FIFO. The serial clock runs at pclk/2 and only during a frame.
//
// Optional feature (compile-time macro): SSP_LOOPBACK_EN
//   When defined, the input i_lbm is added. With i_lbm=1 the receive path
//   samples the internal transmit bit, the ssptxd pin is driven low and the
//   pad output enable stays inactive. When the macro is undefined, received
//   bits always come from i_ssprxd.
//
// Ports
//   i_pclk        sole clock, rising edge
//   i_clear_b     synchronous, active-high reset
//   i_tx_empty    transmit FIFO empty
//   i_tx_data     transmit FIFO head word (valid when i_tx_empty=0)
//   o_tx_pop      one-cycle pop strobe to the transmit FIFO
//   i_rx_full     receive FIFO cannot accept a word
//   o_rx_push     one-cycle push strobe to the receive FIFO
//   o_rx_data     received word; holds the last pushed word between pushes
//   i_ssprxd      serial receive data
//   i_lbm         loopback mode select (only with SSP_LOOPBACK_EN)
//   o_sspclkout   serial clock, pclk/2 during a frame, 0 otherwise
//   o_sspfssout   frame sync, high for one serial-clock period before the MSB
//   o_ssptxd      serial transmit data, MSB first
//   o_sspoe_b     active-low pad output enable
//   o_busy        high whenever the sequencer is not idle
// ----------------------------------------------------------------------------
module ssp_frame_ctrl #(
    parameter int unsigned DW = 8
) (
    input  logic          i_pclk,
    input  logic          i_clear_b,
    input  logic          i_tx_empty,
    input  logic [DW-1:0] i_tx_data,
    output logic          o_tx_pop,
    input  logic          i_rx_full,
    output logic          o_rx_push,
    output logic [DW-1:0] o_rx_data,
    input  logic          i_ssprxd,
`ifdef SSP_LOOPBACK_EN
    input  logic          i_lbm,
`endif
    output logic          o_sspclkout,
    output logic          o_sspfssout,
    output logic          o_ssptxd,
    output logic          o_sspoe_b,
    output logic          o_busy
);

    localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFrame = 2'd1,
        StShift = 2'd2,
        StPush  = 2'd3
    } state_e;

    state_e          r_state;
    logic            r_ph;        // serial-clock phase: 0 = low half, 1 = high half
    logic [CW-1:0]   r_bit_cnt;
    logic [DW-1:0]   r_tx_sr;
    logic [DW-1:0]   r_rx_sr;
    logic [DW-1:0]   r_rx_hold;   // last word actually pushed

    logic            w_lbm;
    logic            w_active;
    logic            w_txd_int;
    logic            w_rx_bit;
    logic            w_tx_pop;
    logic            w_rx_push;
    logic            w_last_bit;

`ifdef SSP_LOOPBACK_EN
    assign w_lbm = i_lbm;
`else
    assign w_lbm = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Strobes. They are combinational so that the FIFO handshake completes in
    // the same cycle that the sequencer decides to start or finish a word.
    // Reset masks both strobes, so a word cannot be lost while clear_b is high.
    // ------------------------------------------------------------------------
    always_comb begin
        w_tx_pop  = 1'b0;
        w_rx_push = 1'b0;
        if (!i_clear_b) begin
            unique case (r_state)
                StIdle: begin
                    w_tx_pop = ~i_tx_empty;
                end
                StPush: begin
                    w_rx_push = ~i_rx_full;
                    w_tx_pop  = ~i_rx_full & ~i_tx_empty;
                end
                default: begin
                    w_tx_pop  = 1'b0;
                    w_rx_push = 1'b0;
                end
            endcase
        end
    end

    assign w_active   = (r_state == StFrame) || (r_state == StShift);
    assign w_txd_int  = (r_state == StShift) ? r_tx_sr[DW-1] : 1'b0;
    assign w_rx_bit   = w_lbm ? w_txd_int : i_ssprxd;
    assign w_last_bit = (r_bit_cnt == CW'(DW - 1));

    // ------------------------------------------------------------------------
    // Sequencer: state, phase, bit counter and both shift registers.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_pclk) begin
        if (i_clear_b) begin
            r_state   <= StIdle;
            r_ph      <= 1'b0;
            r_bit_cnt <= '0;
            r_tx_sr   <= '0;
            r_rx_sr   <= '0;
            r_rx_hold <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_tx_pop) begin
                        r_tx_sr <= i_tx_data;
                        r_ph    <= 1'b0;
                        r_state <= StFrame;
                    end
                end

                // One serial-clock period of frame sync before the MSB.
                StFrame: begin
                    r_ph <= ~r_ph;
                    if (r_ph) begin
                        r_bit_cnt <= '0;
                        r_state   <= StShift;
                    end
                end

                // Sample on the rising serial-clock edge and shift out on the
                // falling one. The next bit is on the pin for the whole low half.
                StShift: begin
                    r_ph <= ~r_ph;
                    if (!r_ph) begin
                        r_rx_sr <= {r_rx_sr[DW-2:0], w_rx_bit};
                    end else begin
                        r_tx_sr   <= {r_tx_sr[DW-2:0], 1'b0};
                        r_bit_cnt <= r_bit_cnt + CW'(1);
                        if (w_last_bit) begin
                            r_state <= StPush;
                        end
                    end
                end

                // Wait here until the receive FIFO has room. The pop for the
                // next word can share the push cycle, so words follow back to back.
                StPush: begin
                    if (w_rx_push) begin
                        r_rx_hold <= r_rx_sr;
                        if (w_tx_pop) begin
                            r_tx_sr <= i_tx_data;
                            r_ph    <= 1'b0;
                            r_state <= StFrame;
                        end else begin
                            r_state <= StIdle;
                        end
                    end
                end

                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs, decoded from registered state only (except the FIFO strobes).
    // ------------------------------------------------------------------------
    assign o_tx_pop    = w_tx_pop;
    assign o_rx_push   = w_rx_push;
    // The new word appears with its push strobe, then stays in r_rx_hold.
    assign o_rx_data   = w_rx_push ? r_rx_sr : r_rx_hold;
    assign o_sspclkout = w_active & r_ph;
    assign o_sspfssout = (r_state == StFrame);
    assign o_ssptxd    = w_lbm ? 1'b0 : w_txd_int;
    assign o_sspoe_b   = ~w_active | w_lbm;
    assign o_busy      = (r_state != StIdle);

endmodule

// File: tb/tb_ssp_frame_ctrl.sv
// ----------------------------------------------------------------------------
// Bench for ssp_frame_ctrl (DW=8). The reference is a timeline model of one
// word. Relative to its pop cycle, cycles 1-2 are the frame-sync period.
// Cycles 3..18 carry bit (7 - (c-3)/2) with the serial clock high on even
// cycles. Cycle 19 (plus any rx_full stall) is the push cycle.
// ----------------------------------------------------------------------------
module tb_ssp_frame_ctrl;

    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          clear_b;
    logic          tx_empty;
    logic [DW-1:0] tx_data;
    logic          tx_pop;
    logic          rx_full;
    logic          rx_push;
    logic [DW-1:0] rx_data;
    logic          ssprxd;
    logic          sclk;
    logic          fss;
    logic          txd;
    logic          oe_b;
    logic          busy;
`ifdef SSP_LOOPBACK_EN
    logic          lbm;
`endif

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            pop_cyc = 0;
    logic [DW-1:0] last_rx = '0;

    ssp_frame_ctrl #(.DW(DW)) dut (
        .i_pclk      (clk),
        .i_clear_b   (clear_b),
        .i_tx_empty  (tx_empty),
        .i_tx_data   (tx_data),
        .o_tx_pop    (tx_pop),
        .i_rx_full   (rx_full),
        .o_rx_push   (rx_push),
        .o_rx_data   (rx_data),
        .i_ssprxd    (ssprxd),
`ifdef SSP_LOOPBACK_EN
        .i_lbm       (lbm),
`endif
        .o_sspclkout (sclk),
        .o_sspfssout (fss),
        .o_ssptxd    (txd),
        .o_sspoe_b   (oe_b),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {tx_pop, rx_push, sclk, fss, txd, oe_b, busy}
    function automatic logic [6:0] outv();
        return {tx_pop, rx_push, sclk, fss, txd, oe_b, busy};
    endfunction

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tx_empty = 1'b1;
            tx_data  = DW'($urandom);
            rx_full  = 1'($urandom_range(0, 1));
            ssprxd   = 1'($urandom_range(0, 1));
            #1;
            check("idle_out", 32'(outv()), 32'(7'b0000010));
            check("idle_rxd", 32'(rx_data), 32'(last_rx));
        end
    endtask

    // Pop cycle from IDLE.
    task automatic start_word(input logic [DW-1:0] tx);
        @(negedge clk);
        tx_empty = 1'b0;
        tx_data  = tx;
        rx_full  = 1'($urandom_range(0, 1));
        #1;
        check("idle_pop", 32'({tx_pop, rx_push, busy}), 32'(3'b100));
        pop_cyc = cyc;
    endtask

    // Cycles 1..18 of a word, any stall cycles and then the push cycle.
    // abort_c > 0 asserts reset during that cycle and returns.
    task automatic word_body(input logic [DW-1:0] tx, input logic [DW-1:0] rx,
                             input int stall, input bit chain,
                             input logic [DW-1:0] next_tx, input bit lb,
                             input int abort_c);
        logic          exp_txd;
        logic [DW-1:0] exp_rx;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            tx_empty = 1'($urandom_range(0, 1));
            tx_data  = DW'($urandom);
            rx_full  = 1'($urandom_range(0, 1));
            if (c >= 3) ssprxd = rx[7 - (c - 3) / 2];
            else        ssprxd = 1'($urandom_range(0, 1));
            if (c == abort_c) clear_b = 1'b1;
            #1;
            exp_txd = 1'b0;
            if (c >= 3 && !lb) exp_txd = tx[7 - (c - 3) / 2];
            check("frame_out", 32'(outv()),
                  32'({2'b00, (c % 2 == 0), (c <= 2), exp_txd, lb, 1'b1}));
            check("frame_rxd", 32'(rx_data), 32'(last_rx));
            if (c == abort_c) return;
        end
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            rx_full  = 1'b1;
            tx_empty = 1'($urandom_range(0, 1));
            ssprxd   = 1'($urandom_range(0, 1));
            #1;
            check("push_hold", 32'({tx_pop, rx_push, sclk, fss, oe_b, busy}),
                  32'(6'b000011));
            check("hold_rxd", 32'(rx_data), 32'(last_rx));
        end
        @(negedge clk);
        rx_full  = 1'b0;
        tx_empty = ~chain;
        tx_data  = next_tx;
        #1;
        exp_rx = lb ? tx : rx;
        check("push_out", 32'({tx_pop, rx_push, sclk, fss, oe_b, busy}),
              32'({chain, 1'b1, 2'b00, 1'b1, 1'b1}));
        check("push_data", 32'(rx_data), 32'(exp_rx));
        check("latency", 32'(cyc - pop_cyc), 32'(19 + stall));
        last_rx = exp_rx;
        if (chain) pop_cyc = cyc;
    endtask

    initial begin
        logic [DW-1:0] tx;
        logic [DW-1:0] nxt;
        bit            chain;

        clear_b  = 1'b1;
        tx_empty = 1'b1;
        tx_data  = '0;
        rx_full  = 1'b0;
        ssprxd   = 1'b0;
`ifdef SSP_LOOPBACK_EN
        lbm      = 1'b0;
`endif
        repeat (3) @(negedge clk);
        #1;
        check("reset_out", 32'(outv()), 32'(7'b0000010));
        check("reset_rxd", 32'(rx_data), 32'(0));
        clear_b = 1'b0;

        // Idle with an empty transmit FIFO.
        idle_cycles(50);

        // Single word A5 out, 3C in.
        start_word(8'hA5);
        word_body(8'hA5, 8'h3C, 0, 1'b0, 8'h00, 1'b0, 0);
        idle_cycles(3);

        // Three queued words: pops 19 cycles apart.
        tx = DW'($urandom);
        start_word(tx);
        for (int k = 0; k < 3; k++) begin
            nxt = DW'($urandom);
            word_body(tx, DW'($urandom), 0, (k < 2), nxt, 1'b0, 0);
            tx = nxt;
        end
        idle_cycles(2);

        // Receive FIFO full for 10 cycles at PUSH.
        tx = DW'($urandom);
        start_word(tx);
        word_body(tx, DW'($urandom), 10, 1'b0, 8'h00, 1'b0, 0);
        idle_cycles(2);

        // Randomised bursts with random stalls and gaps.
        for (int w = 0; w < 6; w++) begin
            tx = DW'($urandom);
            start_word(tx);
            for (int k = 0; k < 4; k++) begin
                chain = (k < 3) && ($urandom_range(0, 1) == 1);
                nxt   = DW'($urandom);
                word_body(tx, DW'($urandom), $urandom_range(0, 3), chain, nxt, 1'b0, 0);
                if (!chain) break;
                tx = nxt;
            end
            idle_cycles($urandom_range(1, 4));
        end

        // Reset during SHIFT bit 4: the partial word is dropped.
        tx = DW'($urandom);
        start_word(tx);
        word_body(tx, DW'($urandom), 0, 1'b0, 8'h00, 1'b0, 11);
        @(negedge clk);
        clear_b  = 1'b0;
        tx_empty = 1'b1;
        #1;
        check("abort_out", 32'(outv()), 32'(7'b0000010));
        check("abort_rxd", 32'(rx_data), 32'(0));
        last_rx = '0;
        idle_cycles(25);

`ifdef SSP_LOOPBACK_EN
        // Loopback: the received word equals the transmitted word and the pin stays 0.
        lbm = 1'b1;
        start_word(8'h96);
        word_body(8'h96, 8'h69, 0, 1'b0, 8'h00, 1'b1, 0);
        idle_cycles(2);
        lbm = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
